// File: rtl/bootram_ctrl.sv
// bootram_ctrl: picorv32 bus and byte-stream loader front end for four 2Kx8 boot RAM lanes
module bootram_ctrl #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic                  ld_en,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  output logic [ADDR_WIDTH+1:0] ld_count,
  output logic [3:0]            ram_ce,
  output logic [3:0]            ram_wre,
  output logic                  ram_oce,
  output logic [ADDR_WIDTH-1:0] ram_ad,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH+1:0] ptr, ptr_eff;
  logic ld_en_q, cpu_q, rd_q, ld_rise, ld_go, cpu_go, unused_addr;
  assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};
  assign ram_oce = 1'b1;
  assign ld_count = ptr;
  assign ld_ready = (state == IDLE) & ld_en;
  assign ld_rise = ld_en & ~ld_en_q;
  assign ptr_eff = ld_rise ? '0 : ptr;
  assign ld_go = ld_valid & ld_ready;
  assign cpu_go = (state == IDLE) & mem_valid & ~ld_en;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // next state: loader writes skip CAPTURE/RESP since they produce no bus response
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE)    ? ((ld_go | cpu_go) ? ACCESS : IDLE) :
              (state == ACCESS)  ? (cpu_q ? CAPTURE : IDLE) :
              (state == CAPTURE) ? RESP : IDLE;
  end
  // registered RAM strobes, response, and load pointer; a rising ld_en restarts the pointer at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      ram_ce    <= '0;
      ram_wre   <= '0;
      ram_ad    <= '0;
      ram_din   <= '0;
      ptr       <= '0;
      ld_en_q   <= 1'b0;
      cpu_q     <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      ld_en_q   <= ld_en;
      mem_ready <= state == CAPTURE;
      ram_ce    <= '0;
      ram_wre   <= '0;
      if (state == CAPTURE && rd_q) mem_rdata <= ram_dout;
      if (ld_rise) ptr <= '0;
      if (ld_go) begin
        ram_ad  <= ptr_eff[ADDR_WIDTH+1:2];
        ram_ce  <= 4'b1 << ptr_eff[1:0];
        ram_wre <= 4'b1 << ptr_eff[1:0];
        ram_din <= {4{ld_data}};
        ptr     <= ptr_eff + 1'b1;
        cpu_q   <= 1'b0;
        rd_q    <= 1'b0;
      end else if (cpu_go) begin
        ram_ad  <= mem_addr[ADDR_WIDTH+1:2];
        ram_ce  <= (mem_wstrb == 4'h0) ? 4'hF : mem_wstrb;
        ram_wre <= mem_wstrb;
        ram_din <= (mem_wstrb == 4'h0) ? ram_din : mem_wdata;
        cpu_q   <= 1'b1;
        rd_q    <= mem_wstrb == 4'h0;
      end
    end
  end
endmodule
